// File: rtl/nibble_feeder_fifo.sv
// rtl/nibble_feeder_fifo.sv - paced FIFO feeding single-cycle load strobes to a 4-bit register stage
module nibble_feeder_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int PACE  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   drain_en,
  output logic                   r_enable,
  output logic [WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    pace_cnt_q, pace_cnt_d;
  logic             r_enable_q, r_enable_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;

  logic full, empty, push, pop;

  // Status comes only from registered state, so wr_ready has no input-to-output path.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push     = wr_valid && !full;
  assign pop      = drain_en && !empty && (pace_cnt_q == '0);

  assign wr_ready = !full;
  assign r_enable = r_enable_q;
  assign data_out = data_out_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    pace_cnt_d = pace_cnt_q;
    if (pop) pace_cnt_d = PACE_RELOAD;
    else if (pace_cnt_q != '0) pace_cnt_d = pace_cnt_q - 1'b1;
    r_enable_d = pop;
    data_out_d = pop ? mem_q[rd_ptr_q] : data_out_q;
    overflow_d = overflow_q || (wr_valid && full);
  end

  // Storage is not cleared on reset; the pointer reset alone discards it.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pace_cnt_q <= '0;
      r_enable_q <= 1'b0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pace_cnt_q <= pace_cnt_d;
      r_enable_q <= r_enable_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/nibble_feeder_fifo.md
Name: nibble_feeder_fifo

Overview:
Small synchronous FIFO that sits directly upstream of the 4-bit load-enable register stage. It accepts nibbles from a producer over a valid/ready handshake. It then replays them into the register's enable/data inputs as single-cycle load strobes, paced by a programmable minimum gap. The FIFO absorbs producer bursts so the register stage never sees back-to-back loads faster than PACE allows.

Parameters:
WIDTH, 4, data word width (matches the register stage).
DEPTH, 4, number of FIFO entries; power of two, >= 2.
PACE, 1, minimum clock cycles between successive load strobes; >= 1.

Ports:
clock  input  1  single system clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
wr_valid  input  1  producer has a word on wr_data.
wr_data  input  WIDTH  word to enqueue.
wr_ready  output  1  FIFO can accept a word this cycle.
drain_en  input  1  permits issuing loads to the register stage.
r_enable  output  1  one-cycle load strobe to the register stage.
data_out  output  WIDTH  word presented with r_enable.
count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky error: write attempted while full.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Nothing is asynchronous.
- Reset (sampled high at a rising edge):
  - count=0; rd/wr pointers=0; pace_cnt=0.
  - r_enable=0, data_out=0, overflow=0.
  - Stored contents discarded. Reset mid-drain drops all queued words.
  - Reset has priority over every other event in that cycle.
- Status: full = (count==DEPTH); empty = (count==0). wr_ready = !full, decoded from registered count only, with no combinational path from wr_valid or drain_en.
- Push: when wr_valid && wr_ready at an edge:
  - mem[wr_ptr] <= wr_data.
  - wr_ptr increments modulo DEPTH (wrap DEPTH-1 -> 0).
- Pop condition, evaluated on pre-edge state: drain_en && !empty && pace_cnt==0.
- Pop, at that edge:
  - r_enable <= 1, data_out <= mem[rd_ptr].
  - rd_ptr increments modulo DEPTH.
  - pace_cnt <= PACE-1.
- No pop at an edge: r_enable <= 0. data_out holds its last value (it is not cleared).
- pace_cnt decrements by 1 every cycle while nonzero, independent of drain_en.
  - PACE=1: pops may occur every cycle.
  - PACE=N: strobes are at least N cycles apart.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when 0<count<DEPTH: both occur, count unchanged, order preserved.
- Full: wr_ready=0, so no push occurs even if a pop happens that same edge. The freed slot is offered the next cycle.
- Empty: no pop. A word written at edge N is first poppable at edge N+1. There is no write-through bypass.
- Latency: write accepted at edge N, FIFO empty, drain_en=1, pace_cnt=0 gives r_enable=1 and data_out=word during the cycle after edge N+1.
- Overflow: set at any edge with wr_valid && !wr_ready. It stays set until reset. The rejected word is dropped and FIFO contents are unaffected.
- Ordering: strict first-in first-out; no word is duplicated or lost except by reset or overflow rejection.
- drain_en low: pops stall, contents retained, pace_cnt still counts down.

Test Plan:
1. Reset: assert reset 2 cycles with wr_valid=1 -> count=0, r_enable=0, data_out=0, overflow=0, wr_ready=1; no word enqueued.
2. Latency: PACE=1, drain_en=1, write 4'd3 at edge N -> r_enable high exactly one cycle after edge N+1 with data_out=3; count returns to 0.
3. Fill and overflow: drain_en=0, write 3,12,5,14 -> count=4, wr_ready=0. A 5th write of 1 sets overflow=1 and count stays 4. Then drain_en=1 -> strobes carry 3,12,5,14 in order and 1 never appears.
4. Pacing: PACE=3, preload 3,12,5,14, raise drain_en -> four r_enable pulses spaced exactly 3 cycles apart; data_out holds 14 after the last pulse.
5. Simultaneous push/pop: count=2, PACE=1, drain_en=1, wr_valid=1 for 4 cycles with values 7,8,9,10 -> count stays 2 throughout; output order is the two preloaded words, then 7,8,9,10. Also check pointer wrap past DEPTH-1.
6. Reset mid-drain: PACE=2, count=3, assert reset during a pace gap -> next cycle count=0, r_enable=0, data_out=0. The following write 4'd6 yields data_out=6 only after 2 cycles, with no stale words emitted.
